// File: rtl/free_list.sv
// rtl/free_list.sv - physical-register free list with per-ROB head checkpoints
//
// Purpose: circular free list of DEPTH = NUM_PR-32 physical tags. One tag is
// allocated per successful dispatch and freed tags are pushed back on retire.
// The head pointer is checkpointed per ROB entry so that a branch rollback
// reclaims every tag allocated after the mispredicted instruction.
//
// Optional feature: FREE_LIST_DUP_CHECK_EN adds a free bitmap and a sticky
// dup_err output that flags double frees and allocation of a non-free tag.
//
// Ports:
//   clock, reset           clock; synchronous active-high reset
//   en                     global stall gate, no state changes when low
//   dispatch_en            allocation request
//   dispatch_rob_idx       ROB tail index of the dispatching instruction
//   retire_en              push retire_T_old back onto the list
//   retire_T_old           tag being freed
//   rollback_en            branch recovery request
//   rollback_rob_idx       ROB index of the mispredicted instruction
//   T_idx                  tag at head, the next tag to be allocated
//   free_valid             at least one tag is free
//   free_hazard            dispatch requested while the list is empty
//   free_count             number of free tags
//   dup_err                (FREE_LIST_DUP_CHECK_EN only) sticky duplicate error
module free_list #(
    parameter int NUM_PR  = 64,
    parameter int NUM_ROB = 32,
    parameter int T_W     = $clog2(NUM_PR),
    parameter int ROB_W   = $clog2(NUM_ROB)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             dispatch_en,
    input  logic [ROB_W-1:0] dispatch_rob_idx,
    input  logic             retire_en,
    input  logic [T_W-1:0]   retire_T_old,
    input  logic             rollback_en,
    input  logic [ROB_W-1:0] rollback_rob_idx,
    output logic [T_W-1:0]   T_idx,
    output logic             free_valid,
    output logic             free_hazard,
    output logic [T_W:0]     free_count
`ifdef FREE_LIST_DUP_CHECK_EN
    ,
    output logic             dup_err
`endif
);

    localparam int DEPTH = NUM_PR - 32;
    localparam int P_W   = $clog2(DEPTH);
    localparam int CNT_W = T_W + 1;

    logic [T_W-1:0]   arr_q  [DEPTH];
    logic [T_W-1:0]   arr_d  [DEPTH];
    logic [P_W-1:0]   ckpt_q [NUM_ROB];
    logic [P_W-1:0]   ckpt_d [NUM_ROB];
    logic [P_W-1:0]   head_q, head_d;
    logic [P_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             pop;
    logic [P_W-1:0]   ck_sel;
    logic [P_W:0]     diff;
    logic [P_W:0]     recl_eff;

    function automatic logic [P_W-1:0] ptr_inc(input logic [P_W-1:0] p);
        return (p == P_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign T_idx       = arr_q[head_q];
    assign free_valid  = (count_q != '0);
    assign free_hazard = dispatch_en && (count_q == '0);
    assign free_count  = count_q;

    // Rollback wins over dispatch in the same cycle.
    assign pop    = dispatch_en && (count_q != '0) && !rollback_en;
    assign ck_sel = ckpt_q[rollback_rob_idx];

    // Number of tags handed out since the checkpoint, modulo DEPTH.
    always_comb begin
        diff = {1'b0, head_q} - {1'b0, ck_sel};
        if (head_q < ck_sel) begin
            diff = diff + (P_W + 1)'(DEPTH);
        end
        recl_eff = rollback_en ? diff : '0;
    end

    always_comb begin
        arr_d   = arr_q;
        ckpt_d  = ckpt_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (en) begin
            if (retire_en) begin
                arr_d[tail_q] = retire_T_old;
                tail_d        = ptr_inc(tail_q);
            end
            if (rollback_en) begin
                head_d = ck_sel;
            end else if (pop) begin
                head_d                   = ptr_inc(head_q);
                ckpt_d[dispatch_rob_idx] = ptr_inc(head_q);
            end
            count_d = count_q - CNT_W'(pop) + CNT_W'(retire_en) + CNT_W'(recl_eff);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                arr_q[i] <= T_W'(32 + i);
            end
            for (int i = 0; i < NUM_ROB; i++) begin
                ckpt_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_W'(DEPTH);
        end else begin
            arr_q   <= arr_d;
            ckpt_q  <= ckpt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

`ifdef FREE_LIST_DUP_CHECK_EN
    localparam logic [NUM_PR-1:0] MAP_RST = {{DEPTH{1'b1}}, 32'b0};

    logic [NUM_PR-1:0] free_map_q, free_map_d;
    logic              dup_q, dup_d;
    logic [P_W-1:0]    rb_pos;

    assign dup_err = dup_q;

    always_comb begin
        free_map_d = free_map_q;
        dup_d      = dup_q;
        rb_pos     = '0;
        if (en) begin
            if (pop) begin
                if (!free_map_q[T_idx]) begin
                    dup_d = 1'b1;
                end
                free_map_d[T_idx] = 1'b0;
            end
            // Reclaimed tags sit in the array from the checkpoint up to head.
            if (rollback_en) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (i < int'(recl_eff)) begin
                        rb_pos                    = P_W'((int'(ck_sel) + i) % DEPTH);
                        free_map_d[arr_q[rb_pos]] = 1'b1;
                    end
                end
            end
            if (retire_en) begin
                if (free_map_q[retire_T_old]) begin
                    dup_d = 1'b1;
                end
                free_map_d[retire_T_old] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            free_map_q <= MAP_RST;
            dup_q      <= 1'b0;
        end else begin
            free_map_q <= free_map_d;
            dup_q      <= dup_d;
        end
    end
`endif

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - self-checking bench for free_list
module tb_free_list;

    logic       clock = 1'b0;
    logic       reset;
    logic       en;
    logic       dispatch_en;
    logic [4:0] dispatch_rob_idx;
    logic       retire_en;
    logic [5:0] retire_T_old;
    logic       rollback_en;
    logic [4:0] rollback_rob_idx;
    logic [5:0] T_idx;
    logic       free_valid;
    logic       free_hazard;
    logic [6:0] free_count;
`ifdef FREE_LIST_DUP_CHECK_EN
    logic       dup_err;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: absolute slot contents, head/tail positions and checkpoints.
    int m_slot [32];
    int m_ck   [32];
    int m_head, m_tail, m_count;

    free_list dut (
        .clock            (clock),
        .reset            (reset),
        .en               (en),
        .dispatch_en      (dispatch_en),
        .dispatch_rob_idx (dispatch_rob_idx),
        .retire_en        (retire_en),
        .retire_T_old     (retire_T_old),
        .rollback_en      (rollback_en),
        .rollback_rob_idx (rollback_rob_idx),
        .T_idx            (T_idx),
        .free_valid       (free_valid),
        .free_hazard      (free_hazard),
        .free_count       (free_count)
`ifdef FREE_LIST_DUP_CHECK_EN
        ,
        .dup_err          (dup_err)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        en               = 1'b1;
        dispatch_en      = 1'b0;
        dispatch_rob_idx = '0;
        retire_en        = 1'b0;
        retire_T_old     = '0;
        rollback_en      = 1'b0;
        rollback_rob_idx = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        @(negedge clock);
        vectors++;
        if (T_idx !== 6'd32) begin
            miscompares++;
            $display("FAIL reset_T_idx got %0d want 32", T_idx);
        end
        vectors++;
        if (free_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_free_valid got %0b want 1", free_valid);
        end
        vectors++;
        if (free_count !== 7'd32) begin
            miscompares++;
            $display("FAIL reset_free_count got %0d want 32", free_count);
        end
        vectors++;
        if (free_hazard !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_free_hazard got %0b want 0", free_hazard);
        end
    endtask

    task automatic test_drain_and_refill();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            dispatch_en      = 1'b1;
            dispatch_rob_idx = 5'(i);
            @(negedge clock);
            vectors++;
            if (T_idx !== 6'(32 + i)) begin
                miscompares++;
                $display("FAIL drain_T_idx[%0d] got %0d want %0d", i, T_idx, 32 + i);
            end
            tick();
        end
        dispatch_en = 1'b0;
        @(negedge clock);
        vectors++;
        if (free_valid !== 1'b0 || free_count !== 7'd0) begin
            miscompares++;
            $display("FAIL empty_state got valid=%0b count=%0d want valid=0 count=0",
                     free_valid, free_count);
        end
        tick();
        dispatch_en = 1'b1;
        @(negedge clock);
        vectors++;
        if (free_hazard !== 1'b1) begin
            miscompares++;
            $display("FAIL empty_hazard got %0b want 1", free_hazard);
        end
        tick();
        dispatch_en = 1'b0;
        @(negedge clock);
        vectors++;
        if (free_count !== 7'd0 || free_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL hazard_no_pop got count=%0d valid=%0b want 0/0", free_count, free_valid);
        end
        // Retire from empty, then dispatch+retire at count 1.
        tick();
        retire_en    = 1'b1;
        retire_T_old = 6'd5;
        tick();
        retire_en = 1'b0;
        @(negedge clock);
        vectors++;
        if (free_valid !== 1'b1 || T_idx !== 6'd5 || free_count !== 7'd1) begin
            miscompares++;
            $display("FAIL retire_from_empty got valid=%0b T_idx=%0d count=%0d want 1/5/1",
                     free_valid, T_idx, free_count);
        end
        tick();
        dispatch_en      = 1'b1;
        dispatch_rob_idx = 5'd0;
        retire_en        = 1'b1;
        retire_T_old     = 6'd7;
        tick();
        idle();
        @(negedge clock);
        vectors++;
        if (free_count !== 7'd1 || T_idx !== 6'd7) begin
            miscompares++;
            $display("FAIL dispatch_retire_count1 got count=%0d T_idx=%0d want 1/7",
                     free_count, T_idx);
        end
        // At count 0, dispatch+retire only pushes.
        tick();
        dispatch_en = 1'b1;
        tick();
        idle();
        tick();
        dispatch_en  = 1'b1;
        retire_en    = 1'b1;
        retire_T_old = 6'd9;
        tick();
        idle();
        @(negedge clock);
        vectors++;
        if (free_count !== 7'd1 || T_idx !== 6'd9) begin
            miscompares++;
            $display("FAIL dispatch_retire_count0 got count=%0d T_idx=%0d want 1/9",
                     free_count, T_idx);
        end
    endtask

    task automatic test_rollback();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            dispatch_en      = 1'b1;
            dispatch_rob_idx = 5'(3 + i);
            tick();
        end
        idle();
        rollback_en      = 1'b1;
        rollback_rob_idx = 5'd3;
        tick();
        idle();
        @(negedge clock);
        vectors++;
        if (T_idx !== 6'd33 || free_count !== 7'd31) begin
            miscompares++;
            $display("FAIL rollback_rob3 got T_idx=%0d count=%0d want 33/31", T_idx, free_count);
        end
        tick();
        rollback_en      = 1'b1;
        rollback_rob_idx = 5'd3;
        dispatch_en      = 1'b1;
        dispatch_rob_idx = 5'd7;
        tick();
        idle();
        @(negedge clock);
        vectors++;
        if (T_idx !== 6'd33 || free_count !== 7'd31) begin
            miscompares++;
            $display("FAIL rollback_with_dispatch got T_idx=%0d count=%0d want 33/31",
                     T_idx, free_count);
        end
        tick();
        dispatch_en      = 1'b1;
        dispatch_rob_idx = 5'd8;
        tick();
        idle();
        // Checkpoint 7 must still hold its reset value 0.
        rollback_en      = 1'b1;
        rollback_rob_idx = 5'd7;
        tick();
        idle();
        @(negedge clock);
        vectors++;
        if (T_idx !== 6'd32 || free_count !== 7'd32) begin
            miscompares++;
            $display("FAIL ckpt_not_written got T_idx=%0d count=%0d want 32/32",
                     T_idx, free_count);
        end
    endtask

    task automatic test_stall_and_reset();
        do_reset();
        dispatch_en      = 1'b1;
        dispatch_rob_idx = 5'd2;
        tick();
        en               = 1'b0;
        dispatch_rob_idx = 5'd9;
        retire_en        = 1'b1;
        retire_T_old     = 6'd50;
        rollback_en      = 1'b1;
        rollback_rob_idx = 5'd2;
        tick();
        rollback_en = 1'b0;
        retire_en   = 1'b0;
        tick();
        idle();
        @(negedge clock);
        vectors++;
        if (T_idx !== 6'd33 || free_count !== 7'd31) begin
            miscompares++;
            $display("FAIL en_low_hold got T_idx=%0d count=%0d want 33/31", T_idx, free_count);
        end
        rollback_en      = 1'b1;
        rollback_rob_idx = 5'd9;
        tick();
        idle();
        @(negedge clock);
        vectors++;
        if (T_idx !== 6'd32 || free_count !== 7'd32) begin
            miscompares++;
            $display("FAIL en_low_ckpt got T_idx=%0d count=%0d want 32/32", T_idx, free_count);
        end
        for (int i = 0; i < 3; i++) begin
            dispatch_en      = 1'b1;
            dispatch_rob_idx = 5'(i);
            tick();
        end
        reset        = 1'b1;
        retire_en    = 1'b1;
        retire_T_old = 6'd3;
        tick();
        reset = 1'b0;
        idle();
        @(negedge clock);
        vectors++;
        if (T_idx !== 6'd32 || free_count !== 7'd32 || free_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset got T_idx=%0d count=%0d valid=%0b want 32/32/1",
                     T_idx, free_count, free_valid);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_slot[i] = 32 + i;
            m_ck[i]   = 0;
        end
        m_head  = 0;
        m_tail  = 0;
        m_count = 32;
    endtask

    task automatic test_random();
        int d, r, rb, e, ri, di, tag, recl, popped;
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            e   = ($urandom_range(0, 9) != 0) ? 1 : 0;
            d   = $urandom_range(0, 1);
            r   = $urandom_range(0, 1);
            rb  = ($urandom_range(0, 11) == 0) ? 1 : 0;
            di  = $urandom_range(0, 31);
            ri  = $urandom_range(0, 31);
            tag = $urandom_range(0, 63);
            if (m_count == 32) r = 0;
            recl = ((m_head - m_ck[ri]) % 32 + 32) % 32;
            if (rb == 1 && m_count + recl + r > 32) rb = 0;
            if (rb == 0) recl = 0;
            en               = e[0];
            dispatch_en      = d[0];
            dispatch_rob_idx = 5'(di);
            retire_en        = r[0];
            retire_T_old     = 6'(tag);
            rollback_en      = rb[0];
            rollback_rob_idx = 5'(ri);
            @(negedge clock);
            vectors++;
            if (T_idx !== 6'(m_slot[m_head]) || free_count !== 7'(m_count) ||
                free_valid !== (m_count > 0) || free_hazard !== (d == 1 && m_count == 0)) begin
                miscompares++;
                $display("FAIL random[%0d] got T_idx=%0d count=%0d valid=%0b hazard=%0b want T_idx=%0d count=%0d",
                         cyc, T_idx, free_count, free_valid, free_hazard, m_slot[m_head], m_count);
            end
            tick();
            if (e == 1) begin
                popped = (d == 1 && m_count > 0 && rb == 0) ? 1 : 0;
                if (r == 1) begin
                    m_slot[m_tail] = tag;
                    m_tail         = (m_tail + 1) % 32;
                end
                if (rb == 1) begin
                    m_head = m_ck[ri];
                end else if (popped == 1) begin
                    m_head   = (m_head + 1) % 32;
                    m_ck[di] = m_head;
                end
                m_count = m_count - popped + r + recl;
            end
        end
        idle();
    endtask

`ifdef FREE_LIST_DUP_CHECK_EN
    task automatic test_dup_check();
        do_reset();
        dispatch_en = 1'b1;
        tick();
        idle();
        @(negedge clock);
        vectors++;
        if (dup_err !== 1'b0) begin
            miscompares++;
            $display("FAIL dup_clean got %0b want 0", dup_err);
        end
        retire_en    = 1'b1;
        retire_T_old = 6'd40;
        tick();
        idle();
        @(negedge clock);
        vectors++;
        if (dup_err !== 1'b1) begin
            miscompares++;
            $display("FAIL dup_set got %0b want 1", dup_err);
        end
        tick();
        tick();
        @(negedge clock);
        vectors++;
        if (dup_err !== 1'b1) begin
            miscompares++;
            $display("FAIL dup_sticky got %0b want 1", dup_err);
        end
        do_reset();
        @(negedge clock);
        vectors++;
        if (dup_err !== 1'b0) begin
            miscompares++;
            $display("FAIL dup_reset got %0b want 0", dup_err);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_drain_and_refill();
        test_rollback();
        test_stall_and_reset();
        test_random();
`ifdef FREE_LIST_DUP_CHECK_EN
        test_dup_check();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Physical-register free list and allocation controller for the R10000-style rename stage.
- Supplies a new physical tag T to the map table and dispatch on every successful dispatch, and reclaims T_old tags on ROB retire.
- Checkpoints its head pointer per ROB entry so a branch rollback restores all tags allocated after the mispredicted instruction, in lockstep with the map-table rollback.

Parameters:
- NUM_PR, 64: number of physical registers. Free-list depth DEPTH = NUM_PR-32.
- NUM_ROB, 32: ROB entries, one head checkpoint each.
- T_W, $clog2(NUM_PR): tag width.
- ROB_W, $clog2(NUM_ROB): ROB index width.

Ports:
- clock, input, 1: clock.
- reset, input, 1: synchronous, active-high.
- en, input, 1: global stall gate; state updates only when en=1 (reset has priority).
- dispatch_en, input, 1: request one allocation (already qualified upstream: dest != r31, ROB/RS not full).
- dispatch_rob_idx, input, ROB_W: ROB tail index of the dispatching instruction.
- retire_en, input, 1: push one freed tag.
- retire_T_old, input, T_W: tag being freed.
- rollback_en, input, 1: branch recovery.
- rollback_rob_idx, input, ROB_W: ROB index of the mispredicted instruction.
- T_idx, output, T_W: tag at head (the tag that will be allocated).
- free_valid, output, 1: count>0.
- free_hazard, output, 1: dispatch_en && count==0 (structural stall to dispatch control).
- free_count, output, T_W+1: number of free tags.

Behaviour:
- Storage: circular array of DEPTH tags, head/tail pointers (log2 DEPTH bits, wrap at DEPTH), count 0..DEPTH, checkpoint array of NUM_ROB head values.
- Reset values: entry i = 32+i; head=0; tail=0; count=DEPTH; all checkpoints 0. T_idx=32, free_valid=1, free_hazard=0, free_count=DEPTH.
- Outputs are combinational from registered state: T_idx=array[head]. No bypass; a retire in cycle N is allocatable in N+1 at the earliest.
- Allocate, when dispatch_en && count>0 && !rollback_en:
  - head<=head+1 mod DEPTH;
  - checkpoint[dispatch_rob_idx]<=head+1 mod DEPTH, i.e. the head after this pop.
- Dispatch with count==0: no pop, no checkpoint write, free_hazard=1 in the same cycle.
- Retire, when retire_en: array[tail]<=retire_T_old; tail<=tail+1 mod DEPTH. This is always accepted. Retire while count==DEPTH is illegal; behaviour is undefined.
- Rollback, when rollback_en:
  - head<=checkpoint[rollback_rob_idx];
  - reclaimed = (head - checkpoint) mod DEPTH;
  - any dispatch_en in the same cycle is ignored (no pop, no checkpoint write).
- Count update: count_next = count - pop + retire + reclaimed. A simultaneous retire is applied in addition to the rollback.
- Simultaneous dispatch+retire at count==1: both occur and count stays 1. At count==0, only the retire occurs, so count becomes 1.
- Reset mid-operation: all pending pops, pushes and rollbacks are discarded; state returns to reset values next edge.
- en=0: no register changes, including checkpoints. Outputs still reflect the current state.

Optional Feature:
- Macro FREE_LIST_DUP_CHECK_EN.
- Defined:
  - Maintain an NUM_PR-bit free bitmap (reset: bits 32..NUM_PR-1 set). Pop clears the bit; retire sets it; rollback sets the bits of all reclaimed tags.
  - Extra output dup_err (1 bit, sticky until reset) is set when retire_T_old's bit is already 1, or when a pop selects a tag whose bit is 0.
- Undefined: no bitmap, no dup_err port; behaviour otherwise identical.

Test Plan:
- Reset, then hold idle -> T_idx=32, free_valid=1, free_count=32, free_hazard=0.
- 32 consecutive dispatches (NUM_PR=64) -> T_idx observed 32..63 in order. Then free_valid=0 and free_count=0; a 33rd dispatch gives free_hazard=1 and state unchanged.
- From empty, retire_T_old=5 -> next cycle free_valid=1, T_idx=5, free_count=1. Dispatch+retire(7) same cycle -> free_count=1, T_idx=7.
- From reset:
  - dispatch rob 3 (alloc 32), then rob 4 (33), then rob 5 (34);
  - rollback_rob_idx=3 -> next cycle T_idx=33, free_count=31.
  - Rollback with concurrent dispatch_en -> no allocation and no checkpoint write for that dispatch.
- en=0 with dispatch_en/retire_en/rollback_en all asserted -> T_idx, free_count and checkpoints unchanged. Reset asserted mid-sequence -> T_idx=32, free_count=32 next cycle.
- With FREE_LIST_DUP_CHECK_EN: after reset, retire_T_old=40 (still free) -> dup_err=1 next cycle and remains 1 until reset.
